gpio_mmio_ctrl: RTL
===================

# gpio_mmio_ctrl

Parametrised, memory-mapped GPIO controller that replaces the fixed single-byte GPIO path on the RISC-V core's data bus. It supports `NUM_PORTS` independent ports of `GPIO_WIDTH` pins each, with:
- per-pin direction;
- atomic set/clear of outputs;
- two-flop input synchronisation;
- per-pin rising/falling-edge interrupt capture into sticky W1C status, combined into one `irq` line to the core.

## Interface
- `GPIO_WIDTH`, default 8: pins per port; legal range 1..32.
- `NUM_PORTS`, default 2: number of ports; legal range 1..8.
- `clk_in`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `bus_we`  in  1  write strobe, one cycle per write.
- `bus_re`  in  1  read strobe, one cycle per read.
- `bus_addr`  in  8  byte address: `[7:5]` = port index, `[4:2]` = register index, `[1:0]` ignored.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, registered.
- `bus_rvalid`  out  1  high for exactly one cycle, one cycle after `bus_re`.
- `gpio_port_in`  in  `NUM_PORTS*GPIO_WIDTH`  asynchronous pin inputs; port p occupies bits `[p*GPIO_WIDTH +: GPIO_WIDTH]`.
- `gpio_port_out`  out  `NUM_PORTS*GPIO_WIDTH`  output data register contents.
- `gpio_port_oe`  out  `NUM_PORTS*GPIO_WIDTH`  output enable, 1 = drive.
- `irq`  out  1  OR of all per-port IRQ_STATUS bits.

## Operation
- Register map per port, by register index:
  - 0 DATA_OUT (RW).
  - 1 DIR (RW, 1 = output).
  - 2 DATA_IN (RO, synchronised pins).
  - 3 SET (WO): DATA_OUT |= wdata.
  - 4 CLR (WO): DATA_OUT &= ~wdata.
  - 5 RISE_EN (RW).
  - 6 FALL_EN (RW).
  - 7 IRQ_STATUS: read returns status; a write clears the bits written as 1 (W1C).
- WO registers read 0.
- Only bits `[GPIO_WIDTH-1:0]` are used. Upper write bits are ignored; upper read bits return 0.
- A port index ≥ `NUM_PORTS` is out of range: writes have no effect, reads return 0 with `bus_rvalid` still asserted.
- `gpio_port_out` follows DATA_OUT regardless of DIR. DIR only drives `gpio_port_oe`.
- Input path per pin is `sync1 -> sync2 -> prev`. DATA_IN = `sync2`.
  - Rising event: `sync2 & ~prev & RISE_EN`.
  - Falling event: `~sync2 & prev & FALL_EN`.
  - Events OR into IRQ_STATUS.
- Edge capture operates on all pins, including pins configured as outputs (loopback is allowed).
- Simultaneous event and W1C on the same bit in the same cycle: the set wins, so the bit stays 1.
- Clearing RISE_EN/FALL_EN does not clear IRQ_STATUS.
- `bus_we` and `bus_re` asserted in the same cycle: the write is performed and the read returns the pre-write value.
- Reset: every register, synchroniser flop and `prev` is set to 0.
  - `gpio_port_out`, `gpio_port_oe`, `bus_rdata`, `bus_rvalid` and `irq` are all 0 in the cycle after `rst` is sampled high.
  - Reset mid-transaction aborts any pending `bus_rvalid`.
  - Pins held high through reset produce a rising event 3 cycles after reset deasserts, only if RISE_EN is set (it cannot be, since RISE_EN resets to 0).

## Timing
- Writes: the register updates on the edge where `bus_we` is sampled. `gpio_port_out` and `gpio_port_oe` change on that same edge (0 extra latency).
- Reads: `bus_re` sampled at edge k; `bus_rdata`/`bus_rvalid` valid after edge k. `bus_rvalid` deasserts after edge k+1 unless `bus_re` is held.
- Back-to-back reads on consecutive cycles are supported, one result per cycle.
- Input path:
  - A pin transition sampled at edge k reaches `sync2` at k+1, so DATA_IN reflects it from k+1.
  - IRQ_STATUS sets at edge k+2.
  - `irq` is combinational from status and rises with it at k+2.
- A pulse shorter than one clock may be missed; this is allowed.

## Test plan
- Reset: drive `rst=1` for 2 cycles with random pins -> all outputs 0; every register reads 0 with `bus_rvalid=1` exactly one cycle after each read.
- Port 1: write DIR=0xFF, DATA_OUT=0x0F, SET 0x30, CLR 0x03 -> `gpio_port_out[15:8]` = 0x0F, 0x3F, 0x3C on successive writes; `gpio_port_oe[15:8]`=0xFF; port 0 outputs unchanged.
- Port 0 edge capture: RISE_EN=0x01, FALL_EN=0x80. Drive pin0 0→1 at edge k and pin7 1→0 -> IRQ_STATUS=0x81 and `irq=1` at k+2. W1C 0x01 -> reads 0x80, `irq` stays 1. W1C 0x80 -> `irq=0`.
- Set-wins race: schedule a rising event on pin2 landing on the same edge as a W1C of bit 2 -> bit 2 reads 1 afterwards.
- Width/range with `GPIO_WIDTH=5`, `NUM_PORTS=3`:
  - Write 0xFFFFFFFF to DATA_OUT of port 2 -> reads 0x1F.
  - Write port index 5 -> no state change; read of port index 5 returns 0 with `bus_rvalid=1`.
- Simultaneous `bus_we`+`bus_re` on DIR (old 0x00, new 0xAA) -> `bus_rdata`=0x00; next read returns 0xAA.

Source files
------------

// File: rtl/gpio_mmio_ctrl.sv
// Memory-mapped GPIO controller: NUM_PORTS ports of GPIO_WIDTH pins, each with
// direction, atomic set/clear, two-flop input sync and sticky W1C edge interrupts.
module gpio_mmio_ctrl #(
  parameter int unsigned GPIO_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 2
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic                            bus_we,
  input  logic                            bus_re,
  input  logic [7:0]                      bus_addr,
  input  logic [31:0]                     bus_wdata,
  output logic [31:0]                     bus_rdata,
  output logic                            bus_rvalid,
  input  logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_port_in,
  output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_port_out,
  output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_port_oe,
  output logic                            irq
);

  localparam int unsigned W = GPIO_WIDTH;

  typedef logic [W-1:0] pin_t;

  localparam logic [2:0] RegDataOut = 3'd0;
  localparam logic [2:0] RegDir     = 3'd1;
  localparam logic [2:0] RegDataIn  = 3'd2;
  localparam logic [2:0] RegSet     = 3'd3;
  localparam logic [2:0] RegClr     = 3'd4;
  localparam logic [2:0] RegRiseEn  = 3'd5;
  localparam logic [2:0] RegFallEn  = 3'd6;
  localparam logic [2:0] RegStatus  = 3'd7;

  pin_t r_data_out [NUM_PORTS];
  pin_t r_dir      [NUM_PORTS];
  pin_t r_rise_en  [NUM_PORTS];
  pin_t r_fall_en  [NUM_PORTS];
  pin_t r_status   [NUM_PORTS];
  pin_t r_sync1    [NUM_PORTS];
  pin_t r_sync2    [NUM_PORTS];
  pin_t r_prev     [NUM_PORTS];

  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic [2:0]           w_port;
  logic [2:0]           w_reg;
  pin_t                 w_wdata;
  pin_t                 w_rd_val;
  logic [NUM_PORTS-1:0] w_wr_sel;
  pin_t                 w_w1c   [NUM_PORTS];
  pin_t                 w_event [NUM_PORTS];
  logic                 w_unused;

  assign w_port   = bus_addr[7:5];
  assign w_reg    = bus_addr[4:2];
  assign w_wdata  = bus_wdata[W-1:0];
  // Byte-lane bits and upper data bits are intentionally ignored.
  assign w_unused = ^{bus_addr[1:0], bus_wdata};

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;

  // Port select for writes (out-of-range ports match no entry) and per-pin edge events.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_wr_sel[p] = bus_we && (w_port == 3'(p));
      w_w1c[p]    = (w_wr_sel[p] && (w_reg == RegStatus)) ? w_wdata : '0;
      w_event[p]  = (r_sync2[p] & ~r_prev[p] & r_rise_en[p])
                  | (~r_sync2[p] & r_prev[p] & r_fall_en[p]);
    end
  end

  // Read mux over pre-write state; out-of-range ports and WO registers give 0.
  always_comb begin
    w_rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_port == 3'(p)) begin
        unique case (w_reg)
          RegDataOut: w_rd_val = r_data_out[p];
          RegDir:     w_rd_val = r_dir[p];
          RegDataIn:  w_rd_val = r_sync2[p];
          RegSet:     w_rd_val = '0;
          RegClr:     w_rd_val = '0;
          RegRiseEn:  w_rd_val = r_rise_en[p];
          RegFallEn:  w_rd_val = r_fall_en[p];
          RegStatus:  w_rd_val = r_status[p];
        endcase
      end
    end
  end

  // Register file, input synchronisers, sticky status and read response.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_data_out[p] <= '0;
        r_dir[p]      <= '0;
        r_rise_en[p]  <= '0;
        r_fall_en[p]  <= '0;
        r_status[p]   <= '0;
        r_sync1[p]    <= '0;
        r_sync2[p]    <= '0;
        r_prev[p]     <= '0;
      end
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus_re;
      if (bus_re) begin
        r_rdata <= 32'(w_rd_val);
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_sync1[p] <= gpio_port_in[p*W +: W];
        r_sync2[p] <= r_sync1[p];
        r_prev[p]  <= r_sync2[p];
        // A new event on the same edge as a W1C keeps the bit set.
        r_status[p] <= (r_status[p] & ~w_w1c[p]) | w_event[p];
        if (w_wr_sel[p]) begin
          case (w_reg)
            RegDataOut: r_data_out[p] <= w_wdata;
            RegDir:     r_dir[p]      <= w_wdata;
            RegSet:     r_data_out[p] <= r_data_out[p] | w_wdata;
            RegClr:     r_data_out[p] <= r_data_out[p] & ~w_wdata;
            RegRiseEn:  r_rise_en[p]  <= w_wdata;
            RegFallEn:  r_fall_en[p]  <= w_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Flatten per-port state onto the pin buses and combine status into irq.
  always_comb begin
    gpio_port_out = '0;
    gpio_port_oe  = '0;
    irq           = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gpio_port_out[p*W +: W] = r_data_out[p];
      gpio_port_oe[p*W +: W]  = r_dir[p];
      irq                     = irq | (|r_status[p]);
    end
  end

endmodule
